// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller.
// Register offsets, FSM encoding and ID width live here.
package irq_pkg;

  localparam int IRQ_ID_W = 4;
  localparam logic [IRQ_ID_W-1:0] IRQ_NONE = 4'hF;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_CUR     = 2'd2;
  localparam logic [1:0] REG_EDGE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder.
// Outputs {valid, id}; id is IRQ_NONE when nothing requests.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]    req,
  output logic                valid,
  output logic [IRQ_ID_W-1:0] id
);

  always_comb begin
    valid = 1'b0;
    id    = IRQ_NONE;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latch, mask, prioritise, INTA/EOI handshake.
// Define IRQ_SYNC_EN to add a 2-flop synchroniser on irq_src.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                STB,
  input  logic                WE,
  input  logic [1:0]          ADDR,
  input  logic [31:0]         DAT_I,
  output logic [31:0]         DAT_O,
  output logic                ACK,
  input  logic [N_SRC-1:0]    irq_src,
  input  logic                INTA,
  output logic                INT,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic                in_service
);

  irq_state_t state, state_d;

  logic [N_SRC-1:0]    s;
  logic [N_SRC-1:0]    src_q;
  logic [N_SRC-1:0]    pending;
  logic [N_SRC-1:0]    mask;
  logic [N_SRC-1:0]    edge_mode;
  logic [N_SRC-1:0]    pend_d;
  logic [N_SRC-1:0]    pend_clr;
  logic [N_SRC-1:0]    take_oh;
  logic [N_SRC-1:0]    rise;
  logic [N_SRC-1:0]    req;
  logic [IRQ_ID_W-1:0] win;
  logic [IRQ_ID_W-1:0] id_d;
  logic                valid;
  logic                wr;
  logic                eoi;
  logic                take;
  logic                unused_dat;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;

  // keyboard ready originates in the clk_scan domain
  always_ff @(posedge clk) begin
    if (!clrn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = irq_src;
`endif

  assign unused_dat = ^DAT_I[31:N_SRC];

  assign ACK = STB;
  assign wr  = STB & WE;
  assign eoi = wr && (ADDR == REG_CUR);

  assign req = pending & mask;

  irq_prio_enc #(
    .N_SRC(N_SRC)
  ) u_enc (
    .req  (req),
    .valid(valid),
    .id   (win)
  );

  assign take    = (state == ASSERT) && INTA && valid;
  assign take_oh = take ? (N_SRC'(1) << win) : '0;
  assign rise    = s & ~src_q;

  assign pend_clr = (wr && (ADDR == REG_PENDING))
                  ? DAT_I[N_SRC-1:0] : '0;

  // a new edge beats a same-cycle clear
  assign pend_d = (~edge_mode & s)
                | (edge_mode & (rise
                  | (pending & ~pend_clr & ~take_oh)));

  always_comb begin
    state_d = state;
    id_d    = irq_id;
    unique case (state)
      IDLE: begin
        if (valid) state_d = ASSERT;
      end
      ASSERT: begin
        if (take) begin
          state_d = SERVICE;
          id_d    = win;
        end else if (!valid) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_d = IDLE;
          id_d    = IRQ_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        id_d    = IRQ_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= IDLE;
      irq_id    <= IRQ_NONE;
      pending   <= '0;
      mask      <= '0;
      edge_mode <= '0;
      src_q     <= '0;
    end else begin
      state   <= state_d;
      irq_id  <= id_d;
      pending <= pend_d;
      src_q   <= s;
      if (wr && (ADDR == REG_MASK))
        mask <= DAT_I[N_SRC-1:0];
      if (wr && (ADDR == REG_EDGE))
        edge_mode <= DAT_I[N_SRC-1:0];
    end
  end

  assign INT        = (state == ASSERT);
  assign in_service = (state == SERVICE);

  always_comb begin
    DAT_O = '0;
    if (STB) begin
      unique case (ADDR)
        REG_PENDING: DAT_O = 32'(pending);
        REG_MASK:    DAT_O = 32'(mask);
        REG_CUR:     DAT_O = {in_service, 27'b0, irq_id};
        REG_EDGE:    DAT_O = 32'(edge_mode);
        default:     DAT_O = '0;
      endcase
    end
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller that shares the single CPU interrupt line among peripheral requesters: keyboard `INT` (ready), timer, UART, and so on.
- Latches requests, masks and prioritises them, and presents one `INT` to the CPU.
- Sequences the acknowledge and end-of-interrupt handshake.
- Sits on the peripheral bus beside the keyboard, using the same `STB`/`ACK`/`WE` slave protocol.

Parameters:
- N_SRC, 4, number of interrupt sources (1..15). Source 0 has the highest priority.

Ports:
- clk  in  1  system clock.
- clrn  in  1  reset, synchronous, active-low.
- STB  in  1  bus strobe, slave selected.
- WE  in  1  bus write enable, qualified by `STB`.
- ADDR  in  2  word offset of the register being accessed.
- DAT_I  in  32  bus write data.
- DAT_O  out  32  bus read data.
- ACK  out  1  bus acknowledge.
- irq_src  in  N_SRC  raw interrupt requests from peripherals.
- INTA  in  1  CPU interrupt acknowledge, one-cycle pulse.
- INT  out  1  interrupt request to the CPU.
- irq_id  out  4  ID of the source being serviced; valid in SERVICE.
- in_service  out  1  high while in SERVICE.

Behaviour:
- Reset (clrn=0 at a clk edge):
  - PENDING, MASK, EDGE, src_q and the sync stages all clear to 0.
  - State goes to IDLE; irq_id=4'hF, INT=0, in_service=0.
- Bus access:
  - ACK=STB (combinational, zero wait states).
  - Reads are combinational: DAT_O = selected register when STB is high, else 0.
  - Writes take effect at the clk edge where STB&WE is high.
- Register map:
  - 0: PENDING. Read. Write-1-to-clear, edge sources only.
  - 1: MASK. Read/write. 1 = enabled.
  - 2: CUR. Read returns {in_service, 27'b0, irq_id}. Any write is EOI.
  - 3: EDGE. Read/write. 1 = edge-triggered, 0 = level.
  - Bits at or above N_SRC read 0 and ignore writes.
- Source sampling (s = sampled irq_src):
  - src_q holds the previous s.
  - Level source: PENDING[i] <= s[i] every cycle; not sticky, and write-1-to-clear is ignored.
  - Edge source: PENDING[i] is set on s[i]&~src_q[i]. It stays set until write-1-to-clear or INTA selects it.
  - If set and clear occur on the same edge, set wins.
- Arbitration: req = PENDING & MASK. Winner = lowest set index of req, via the priority encoder.
- FSM states are IDLE, ASSERT, SERVICE.
  - IDLE: go to ASSERT if req != 0. INTA is ignored.
  - ASSERT: INT=1 (registered, from the state).
    - If req becomes 0 (level source dropped or mask cleared), return to IDLE and INT=0 next cycle.
    - On INTA with req != 0: irq_id <= winner, clear PENDING[winner] if it is an edge source, go to SERVICE.
  - SERVICE: INT=0 and in_service=1; irq_id is held. An EOI write goes to IDLE and sets irq_id=4'hF.
  - The EOI data value is ignored. EOI in IDLE or ASSERT is ignored.
  - No nesting: new requests pend during SERVICE.
- Latency:
  - Sampling edge → PENDING set at the same edge.
  - INT high after the next edge, i.e. 2 edges after the source is first sampled.
  - Back-to-back: after EOI, another pending source drives INT=1 one cycle after reaching IDLE.
- Reset mid-operation: an in-flight service is abandoned, all state clears, and INT drops after that edge.

Optional Feature:
- IRQ_SYNC_EN defined:
  - irq_src passes through a 2-flop synchroniser per bit before s, because the keyboard ready comes from the clk_scan domain.
  - This adds 2 cycles to all latencies.
- Not defined: s = irq_src directly; sources must be synchronous to clk.

Decomposition:
- Package irq_pkg holds:
  - Register offsets REG_PENDING=0, REG_MASK=1, REG_CUR=2, REG_EDGE=3.
  - FSM state encoding (IDLE=2'd0, ASSERT=2'd1, SERVICE=2'd2).
  - IRQ_ID_W=4 and IRQ_NONE=4'hF.
- Sub-module irq_prio_enc: combinational N_SRC-bit lowest-index priority encoder, outputs {valid, id}.

Test Plan:
- Reset, then read every register: PENDING=0, MASK=0, EDGE=0, CUR=32'h0000000F. INT=0.
- EDGE=4'b0001, MASK=4'b0001, pulse irq_src[0] for 1 cycle:
  - INT=1 two edges later, and 4 edges later with IRQ_SYNC_EN.
  - INTA gives irq_id=0, PENDING[0]=0, INT=0.
  - CUR write returns irq_id to 4'hF.
- MASK=4'b1111, EDGE=4'b1111, pulse sources 3 and 1 together:
  - First INTA gives irq_id=1; after EOI, INT re-asserts and the second INTA gives irq_id=3.
- Level source 2 (EDGE[2]=0, MASK[2]=1) held high then dropped while in ASSERT without INTA:
  - INT falls one cycle after the drop and PENDING[2]=0.
- Edge on source 0 on the same edge as write-1-to-clear of PENDING bit 0: PENDING[0] stays 1.
- Assert clrn=0 while in SERVICE with irq_id=1: next cycle in_service=0, irq_id=4'hF, MASK=0.
